id_ex_shift_stage: RTL and testbench
====================================

Name: id_ex_shift_stage

Overview:
- ID/EX pipeline register for the shift datapath. Sits directly upstream of the EX-stage shifter.
- Captures decoded shift instructions (SLL/SRA/ROR): source operand, 4-bit immediate amount, shift type and destination.
- Resolves RAW hazards on the source operand by forwarding from EX/MEM and MEM/WB, then drives the shifter's data, amount and opcode inputs.
- Supports pipeline stall (hold) and flush (bubble insertion), and counts inserted bubbles.

Parameters:
- DW, 16, datapath width.
- RW, 4, register address width.
- BCW, 8, bubble counter width.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold current EX contents
- flush  in  1  replace EX contents with bubble
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  2  shift type: 00 SLL, 01 SRA, 1x ROR
- id_rs_addr  in  RW  source register number
- id_rs_data  in  DW  register-file read data for rs
- id_imm  in  4  shift amount
- id_rd_addr  in  RW  destination register
- id_reg_write  in  1  instruction writes rd
- exmem_reg_write  in  1  EX/MEM producer writes
- exmem_rd_addr  in  RW  EX/MEM destination
- exmem_result  in  DW  EX/MEM result
- memwb_reg_write  in  1  MEM/WB producer writes
- memwb_rd_addr  in  RW  MEM/WB destination
- memwb_result  in  DW  MEM/WB writeback data
- ex_valid  out  1  EX holds a real instruction
- ex_shift_in  out  DW  operand to shifter (forwarded)
- ex_shift_val  out  4  shift amount to shifter
- ex_shift_op  out  2  opcode to shifter
- ex_rd_addr  out  RW  registered destination
- ex_reg_write  out  1  registered write enable, forced 0 when ex_valid=0
- bubble_cnt  out  BCW  saturating count of bubbles loaded

Behaviour:
- Clock and reset: single clock domain, clk. Reset is synchronous and active-high, on rst.
- Reset values: all registered fields are 0 (ex_valid=0, ex_reg_write=0, ex_shift_op=00, ex_shift_val=0, ex_rd_addr=0, stored rs data/addr=0, bubble_cnt=0). ex_shift_in therefore reads 0.
- Per-edge priority: rst > flush > stall > load.
- flush=1: load a bubble. valid=0, reg_write=0, all other fields cleared to 0. Flush overrides a simultaneous stall. bubble_cnt increments.
- stall=1, flush=0: all fields hold, except stored rs data. Stored rs data is overwritten with the current forwarded value (ex_shift_in). This ensures a held instruction keeps a producer value after that producer retires past MEM/WB. bubble_cnt holds.
- Load (neither flush nor stall): capture all id_* fields; ex_valid<=id_valid.
  - If id_valid=0, this is a bubble: reg_write forced 0, and bubble_cnt increments.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- Forwarding (combinational from registered rs addr/data):
  - EX/MEM match: exmem_reg_write=1 and exmem_rd_addr==rs_q and rs_q!=0 -> exmem_result.
  - Else MEM/WB match (same rule) -> memwb_result.
  - Else stored rs data.
  - EX/MEM has priority over MEM/WB when both match.
  - R0 is never forwarded.
  - Forwarding is applied regardless of ex_valid; the output is don't-care when ex_valid=0 but must be deterministic.
- ex_shift_val and ex_shift_op are pure registered fields with no combinational path from inputs.
- bubble_cnt: saturates at 2^BCW-1 and does not wrap. It is cleared only by rst.
- Reset mid-stall or mid-flush: reset wins. Outputs take reset values on the next edge.

Test Plan:
- Reset then load id_valid=1, op=01, rs=3, rs_data=16'h8001, imm=4, rd=5, rw=1 -> next cycle: ex_valid=1, ex_shift_in=8001, ex_shift_val=4, ex_shift_op=01, ex_rd_addr=5, ex_reg_write=1.
- EX rs=3 with exmem(rw=1, rd=3, 16'h1234) and memwb(rw=1, rd=3, 16'hABCD) -> ex_shift_in=1234. Drop exmem_reg_write -> ABCD. With rs=0 and both producers matching rd=0 -> stored data.
- Stall 3 cycles with memwb(rd=3, 16'h00F0) valid only in stall cycle 1 -> ex_shift_in stays 00F0 through cycles 2-3 after memwb changes; other fields unchanged.
- stall=1 and flush=1 same edge -> ex_valid=0, ex_reg_write=0, bubble_cnt +1.
- Load 260 consecutive id_valid=0 cycles with BCW=8 -> bubble_cnt=255, no wrap. Then rst=1 for one edge -> bubble_cnt=0, ex_valid=0.
- rst asserted while stalled with a valid instruction held -> next edge: all outputs at reset values. Deasserting rst resumes normal loads.

Source files
------------

// File: rtl/id_ex_shift_stage.sv
// ID/EX register for the shift datapath with RAW forwarding from EX/MEM and MEM/WB; 1-cycle latency.
// stall holds the stage (rs data refreshed from the forward mux); flush or an invalid load inserts a counted bubble.
module id_ex_shift_stage #(
    parameter int DW  = 16,
    parameter int RW  = 4,
    parameter int BCW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall,
    input  logic           flush,
    input  logic           id_valid,
    input  logic [1:0]     id_opcode,
    input  logic [RW-1:0]  id_rs_addr,
    input  logic [DW-1:0]  id_rs_data,
    input  logic [3:0]     id_imm,
    input  logic [RW-1:0]  id_rd_addr,
    input  logic           id_reg_write,
    input  logic           exmem_reg_write,
    input  logic [RW-1:0]  exmem_rd_addr,
    input  logic [DW-1:0]  exmem_result,
    input  logic           memwb_reg_write,
    input  logic [RW-1:0]  memwb_rd_addr,
    input  logic [DW-1:0]  memwb_result,
    output logic           ex_valid,
    output logic [DW-1:0]  ex_shift_in,
    output logic [3:0]     ex_shift_val,
    output logic [1:0]     ex_shift_op,
    output logic [RW-1:0]  ex_rd_addr,
    output logic           ex_reg_write,
    output logic [BCW-1:0] bubble_cnt
);

    logic           r_valid;
    logic [1:0]     r_op;
    logic [3:0]     r_imm;
    logic [RW-1:0]  r_rd_addr;
    logic           r_reg_write;
    logic [RW-1:0]  r_rs_addr;
    logic [DW-1:0]  r_rs_data;
    logic [BCW-1:0] r_bubble_cnt;

    logic           w_rs_nonzero;
    logic           w_exmem_hit;
    logic           w_memwb_hit;
    logic [DW-1:0]  w_fwd_data;
    logic           w_bubble;
    logic [BCW-1:0] w_bubble_cnt_inc;

    // R0 is hardwired zero, so producers targeting it are never forwarded.
    assign w_rs_nonzero = (r_rs_addr != '0);
    assign w_exmem_hit  = exmem_reg_write && (exmem_rd_addr == r_rs_addr) && w_rs_nonzero;
    assign w_memwb_hit  = memwb_reg_write && (memwb_rd_addr == r_rs_addr) && w_rs_nonzero;

    always_comb begin
        w_fwd_data = r_rs_data;
        if (w_exmem_hit) begin
            w_fwd_data = exmem_result;
        end else if (w_memwb_hit) begin
            w_fwd_data = memwb_result;
        end
    end

    assign w_bubble         = flush || (!stall && !id_valid);
    assign w_bubble_cnt_inc = (&r_bubble_cnt) ? r_bubble_cnt : r_bubble_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_op         <= 2'b00;
            r_imm        <= 4'd0;
            r_rd_addr    <= '0;
            r_reg_write  <= 1'b0;
            r_rs_addr    <= '0;
            r_rs_data    <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (flush) begin
                r_valid     <= 1'b0;
                r_op        <= 2'b00;
                r_imm       <= 4'd0;
                r_rd_addr   <= '0;
                r_reg_write <= 1'b0;
                r_rs_addr   <= '0;
                r_rs_data   <= '0;
            end else if (stall) begin
                // Latch the forwarded value so a held op survives its producer retiring.
                r_rs_data <= w_fwd_data;
            end else begin
                r_valid     <= id_valid;
                r_op        <= id_opcode;
                r_imm       <= id_imm;
                r_rd_addr   <= id_rd_addr;
                r_reg_write <= id_valid && id_reg_write;
                r_rs_addr   <= id_rs_addr;
                r_rs_data   <= id_rs_data;
            end
            if (w_bubble) begin
                r_bubble_cnt <= w_bubble_cnt_inc;
            end
        end
    end

    assign ex_valid     = r_valid;
    assign ex_shift_in  = w_fwd_data;
    assign ex_shift_val = r_imm;
    assign ex_shift_op  = r_op;
    assign ex_rd_addr   = r_rd_addr;
    assign ex_reg_write = r_reg_write && r_valid;
    assign bubble_cnt   = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_shift_stage.sv
// Directed plus random checks of id_ex_shift_stage against a cycle-level behavioural model.
module tb_id_ex_shift_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        id_valid, id_reg_write;
    logic [1:0]  id_opcode;
    logic [3:0]  id_rs_addr, id_imm, id_rd_addr;
    logic [15:0] id_rs_data;
    logic        exmem_reg_write, memwb_reg_write;
    logic [3:0]  exmem_rd_addr, memwb_rd_addr;
    logic [15:0] exmem_result, memwb_result;
    logic        ex_valid, ex_reg_write;
    logic [15:0] ex_shift_in;
    logic [3:0]  ex_shift_val, ex_rd_addr;
    logic [1:0]  ex_shift_op;
    logic [7:0]  bubble_cnt;

    always #5 clk = ~clk;

    id_ex_shift_stage #(.DW(16), .RW(4), .BCW(8)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_rs_addr(id_rs_addr),
        .id_rs_data(id_rs_data), .id_imm(id_imm), .id_rd_addr(id_rd_addr),
        .id_reg_write(id_reg_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_shift_in(ex_shift_in), .ex_shift_val(ex_shift_val),
        .ex_shift_op(ex_shift_op), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .bubble_cnt(bubble_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: what the EX stage should hold, as plain variables.
    bit       m_valid, m_rw;
    int       m_op, m_imm, m_rd, m_rs, m_data, m_bcnt;

    function automatic int model_operand();
        if (m_rs != 0 && exmem_reg_write && int'(exmem_rd_addr) == m_rs) return int'(exmem_result);
        if (m_rs != 0 && memwb_reg_write && int'(memwb_rd_addr) == m_rs) return int'(memwb_result);
        return m_data;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, m_valid});
        chk({tag, ".shift_in"}, {16'd0, ex_shift_in}, model_operand());
        chk({tag, ".shift_val"}, {28'd0, ex_shift_val}, m_imm);
        chk({tag, ".shift_op"}, {30'd0, ex_shift_op}, m_op);
        chk({tag, ".rd"}, {28'd0, ex_rd_addr}, m_rd);
        chk({tag, ".reg_write"}, {31'd0, ex_reg_write}, {31'd0, m_rw});
        chk({tag, ".bubbles"}, {24'd0, bubble_cnt}, m_bcnt);
    endtask

    function automatic void model_clear();
        m_valid = 0; m_rw = 0; m_op = 0; m_imm = 0; m_rd = 0; m_rs = 0; m_data = 0;
    endfunction

    // Advance one clock: model computes next state from current inputs, then compare.
    task automatic cycle(input string tag);
        int fwd;
        fwd = model_operand();
        if (rst) begin
            model_clear();
            m_bcnt = 0;
        end else if (flush) begin
            model_clear();
            if (m_bcnt < 255) m_bcnt++;
        end else if (stall) begin
            m_data = fwd;
        end else begin
            m_valid = id_valid;
            m_op    = id_opcode;
            m_imm   = id_imm;
            m_rd    = id_rd_addr;
            m_rs    = id_rs_addr;
            m_data  = id_rs_data;
            m_rw    = id_valid && id_reg_write;
            if (!id_valid && m_bcnt < 255) m_bcnt++;
        end
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic idle_inputs();
        rst = 0; stall = 0; flush = 0;
        id_valid = 0; id_opcode = 0; id_rs_addr = 0; id_rs_data = 0;
        id_imm = 0; id_rd_addr = 0; id_reg_write = 0;
        exmem_reg_write = 0; exmem_rd_addr = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd_addr = 0; memwb_result = 0;
    endtask

    task automatic load(input logic [1:0] op, input logic [3:0] rs, input logic [15:0] d,
                        input logic [3:0] imm, input logic [3:0] rd, input logic rw);
        id_valid = 1; id_opcode = op; id_rs_addr = rs; id_rs_data = d;
        id_imm = imm; id_rd_addr = rd; id_reg_write = rw;
    endtask

    int bc_before;

    initial begin
        idle_inputs();
        model_clear();
        m_bcnt = 0;
        rst = 1;
        cycle("reset");
        chk("reset.valid_const", {31'd0, ex_valid}, 0);
        chk("reset.shift_in_const", {16'd0, ex_shift_in}, 0);
        rst = 0;

        load(2'b01, 4'd3, 16'h8001, 4'd4, 4'd5, 1'b1);
        cycle("load1");
        chk("load1.shift_in_const", {16'd0, ex_shift_in}, 32'h8001);
        chk("load1.op_const", {30'd0, ex_shift_op}, 1);

        // Combinational forwarding on the held instruction (rs=3).
        stall = 1; id_valid = 0;
        exmem_reg_write = 1; exmem_rd_addr = 3; exmem_result = 16'h1234;
        memwb_reg_write = 1; memwb_rd_addr = 3; memwb_result = 16'hABCD;
        #1 chk("fwd.exmem_prio", {16'd0, ex_shift_in}, 32'h1234);
        exmem_reg_write = 0;
        #1 chk("fwd.memwb", {16'd0, ex_shift_in}, 32'hABCD);
        stall = 0; exmem_reg_write = 0; memwb_reg_write = 0;
        load(2'b00, 4'd0, 16'h5555, 4'd1, 4'd2, 1'b1);
        cycle("load_r0");
        exmem_reg_write = 1; exmem_rd_addr = 0; memwb_reg_write = 1; memwb_rd_addr = 0;
        #1 chk("fwd.r0_never", {16'd0, ex_shift_in}, 32'h5555);
        exmem_reg_write = 0; memwb_reg_write = 0;

        // Stall keeps a producer value after it leaves MEM/WB.
        load(2'b10, 4'd3, 16'h1111, 4'd7, 4'd9, 1'b1);
        cycle("load_stall");
        id_valid = 0; stall = 1;
        memwb_reg_write = 1; memwb_rd_addr = 3; memwb_result = 16'h00F0;
        cycle("stall1");
        memwb_reg_write = 0; memwb_result = 16'hDEAD;
        cycle("stall2");
        chk("stall2.held_const", {16'd0, ex_shift_in}, 32'h00F0);
        cycle("stall3");
        chk("stall3.held_const", {16'd0, ex_shift_in}, 32'h00F0);
        chk("stall3.imm_const", {28'd0, ex_shift_val}, 7);

        bc_before = int'(bubble_cnt);
        flush = 1;
        cycle("stall_flush");
        chk("flush.bubble_inc", {24'd0, bubble_cnt}, bc_before + 1);
        flush = 0; stall = 0;

        id_valid = 0;
        for (int i = 0; i < 260; i++) cycle("bubble_sat");
        chk("bubble_sat_const", {24'd0, bubble_cnt}, 255);
        rst = 1;
        cycle("sat_reset");
        chk("sat_reset_const", {24'd0, bubble_cnt}, 0);
        rst = 0;

        load(2'b01, 4'd6, 16'hC0DE, 4'd2, 4'd8, 1'b1);
        cycle("pre_rst_load");
        id_valid = 0; stall = 1; rst = 1;
        cycle("rst_in_stall");
        chk("rst_in_stall.valid_const", {31'd0, ex_valid}, 0);
        rst = 0; stall = 0;
        load(2'b00, 4'd2, 16'h0F0F, 4'd3, 4'd4, 1'b1);
        cycle("resume");
        chk("resume.valid_const", {31'd0, ex_valid}, 1);

        for (int i = 0; i < 400; i++) begin
            rst             = ($urandom_range(0, 49) == 0);
            flush           = ($urandom_range(0, 9) == 0);
            stall           = ($urandom_range(0, 3) == 0);
            id_valid        = ($urandom_range(0, 3) != 0);
            id_opcode       = 2'($urandom);
            id_rs_addr      = 4'($urandom_range(0, 3));
            id_rs_data      = 16'($urandom);
            id_imm          = 4'($urandom);
            id_rd_addr      = 4'($urandom);
            id_reg_write    = 1'($urandom);
            exmem_reg_write = 1'($urandom);
            exmem_rd_addr   = 4'($urandom_range(0, 3));
            exmem_result    = 16'($urandom);
            memwb_reg_write = 1'($urandom);
            memwb_rd_addr   = 4'($urandom_range(0, 3));
            memwb_result    = 16'($urandom);
            cycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
